// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : player_pkg
// Purpose  : State encoding and shared constants for the voice mixers.
// Revision : 1.0
// ============================================================================
package player_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    MIX     = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int c_default_sample_width = 16;
  // Headroom for summing up to eight full-scale voices.
  localparam int c_acc_guard_bits = 3;

endpackage
`default_nettype wire

// File: rtl/sat_shift.sv
`default_nettype none
// ============================================================================
// Module   : sat_shift
// Purpose  : Arithmetic right shift followed by saturation to a narrower
//            signed width.
// Revision : 1.0
// ============================================================================
module sat_shift #(
  parameter int IN_WIDTH  = 19,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 2
) (
  input  logic signed [IN_WIDTH-1:0]  i_value,
  output logic signed [OUT_WIDTH-1:0] o_value
);

  localparam logic signed [IN_WIDTH-1:0] c_max =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] c_min =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0] w_shifted;

  assign w_shifted = i_value >>> SHIFT;

  always_comb begin
    o_value = w_shifted[OUT_WIDTH-1:0];
    if (w_shifted > c_max) begin
      o_value = c_max[OUT_WIDTH-1:0];
    end else if (w_shifted < c_min) begin
      o_value = c_min[OUT_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/poly_codec_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : poly_codec_conditioner
// Purpose  : Collects one sample per frame from each voice, mixes the enabled
//            voices with gain shift and saturation, and presents it on ticks.
// Revision : 1.0
// ============================================================================
module poly_codec_conditioner
  import player_pkg::*;
#(
  parameter int NUM_VOICES     = 4,
  parameter int SAMPLE_WIDTH   = c_default_sample_width,
  parameter int GAIN_SHIFT     = 2,
  parameter int UNDERRUN_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_frame,
  input  logic [NUM_VOICES-1:0]              voice_enable,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]              voice_ready,
  output logic                               generate_next_sample,
  output logic [SAMPLE_WIDTH-1:0]            valid_sample,
  output logic                               underrun,
  output logic [UNDERRUN_WIDTH-1:0]          underrun_count
);

  localparam int c_acc_width = SAMPLE_WIDTH + c_acc_guard_bits;
  localparam int c_idx_width = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [c_idx_width-1:0] c_last_idx = c_idx_width'(NUM_VOICES - 1);

  state_t                         r_state, w_state_next;
  logic                           r_nf_q;
  logic                           w_tick;
  logic                           w_all_in;
  logic                           w_mixing;
  logic [NUM_VOICES-1:0]          r_enable;
  logic [NUM_VOICES-1:0]          w_got;
  logic signed [SAMPLE_WIDTH-1:0] w_sample [NUM_VOICES];
  logic signed [c_acc_width-1:0]  r_acc, w_addend, w_acc_sum;
  logic [c_idx_width-1:0]         r_idx;
  logic signed [SAMPLE_WIDTH-1:0] r_staged, r_valid, w_mix_sat;
  logic                           r_gen, r_underrun;
  logic [UNDERRUN_WIDTH-1:0]      r_count;

  assign w_tick   = new_frame & ~r_nf_q;
  assign w_all_in = &(w_got | ~r_enable);
  assign w_mixing = (r_state == COLLECT) || (r_state == MIX);

  // A ready strobe beats the tick clear so it lands in the new round.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic signed [SAMPLE_WIDTH-1:0] r_smp;
    logic                           r_got;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_smp <= '0;
        r_got <= 1'b0;
      end else if (voice_ready[gi]) begin
        r_smp <= voice_sample[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        r_got <= 1'b1;
      end else if (w_tick) begin
        r_got <= 1'b0;
      end
    end

    assign w_sample[gi] = r_smp;
    assign w_got[gi]    = r_got;
  end

  always_comb begin
    w_addend = '0;
    if (r_enable[r_idx]) begin
      w_addend = c_acc_width'(w_sample[r_idx]);
    end
  end

  assign w_acc_sum = r_acc + w_addend;

  sat_shift #(
    .IN_WIDTH  (c_acc_width),
    .OUT_WIDTH (SAMPLE_WIDTH),
    .SHIFT     (GAIN_SHIFT)
  ) u_sat_shift (
    .i_value (w_acc_sum),
    .o_value (w_mix_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      w_state_next = COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (w_all_in) w_state_next = MIX;
        MIX:     if (r_idx == c_last_idx) w_state_next = DONE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nf_q     <= 1'b1;
      r_enable   <= '0;
      r_gen      <= 1'b0;
      r_underrun <= 1'b0;
      r_count    <= '0;
      r_valid    <= '0;
      r_staged   <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
    end else begin
      r_nf_q     <= new_frame;
      r_gen      <= w_tick;
      r_underrun <= w_tick & w_mixing;
      if (w_tick) begin
        r_enable <= voice_enable;
        if (r_state == DONE) begin
          r_valid <= r_staged;
        end
        if (w_mixing && (r_count != '1)) begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        case (r_state)
          COLLECT: begin
            if (w_all_in) begin
              r_acc <= '0;
              r_idx <= '0;
            end
          end
          MIX: begin
            r_acc <= w_acc_sum;
            r_idx <= r_idx + 1'b1;
            if (r_idx == c_last_idx) begin
              r_staged <= w_mix_sat;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign generate_next_sample = r_gen;
  assign valid_sample         = r_valid;
  assign underrun             = r_underrun;
  assign underrun_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_poly_codec_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_codec_conditioner
// Purpose  : Frame-level randomized bench with a behavioural mix model; two
//            instances cover gain shifts of 2 and 0.
// Revision : 1.0
// ============================================================================
module tb_poly_codec_conditioner;

  localparam int N = 4;
  localparam int W = 16;

  typedef int arr_t [N];

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           new_frame = 1'b0;
  logic [N-1:0]   voice_enable = '0;
  logic [N-1:0]   voice_ready = '0;
  logic [N*W-1:0] voice_sample = '0;

  logic           gen2, und2, gen0, und0;
  logic [W-1:0]   valid2, valid0;
  logic [7:0]     cnt2, cnt0;

  always #5 clk = ~clk;

  poly_codec_conditioner #(
    .NUM_VOICES(N), .SAMPLE_WIDTH(W), .GAIN_SHIFT(2), .UNDERRUN_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame),
    .voice_enable(voice_enable), .voice_sample(voice_sample),
    .voice_ready(voice_ready), .generate_next_sample(gen2),
    .valid_sample(valid2), .underrun(und2), .underrun_count(cnt2)
  );

  poly_codec_conditioner #(
    .NUM_VOICES(N), .SAMPLE_WIDTH(W), .GAIN_SHIFT(0), .UNDERRUN_WIDTH(8)
  ) dut_s0 (
    .clk(clk), .reset(reset), .new_frame(new_frame),
    .voice_enable(voice_enable), .voice_sample(voice_sample),
    .voice_ready(voice_ready), .generate_next_sample(gen0),
    .valid_sample(valid0), .underrun(und0), .underrun_count(cnt0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Frame-level model: what each round collected and when.
  bit           m_nf;
  bit           m_started;
  bit           m_exp_und;
  int           m_last_tick;
  int           m_round_start;
  int           m_valid2, m_valid0, m_cnt;
  logic [N-1:0] m_mask;
  bit           m_rd   [N];
  int           m_val  [N];
  int           m_rcyc [N];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic int sat_mix(input int sum, input int sh);
    int v;
    v = sum >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic void model_reset();
    m_nf = 1'b1;
    m_started = 1'b0;
    m_exp_und = 1'b0;
    m_last_tick = -100;
    m_round_start = 0;
    m_valid2 = 0;
    m_valid0 = 0;
    m_cnt = 0;
    m_mask = '0;
    for (int i = 0; i < N; i++) begin
      m_rd[i] = 1'b0;
      m_val[i] = 0;
      m_rcyc[i] = 0;
    end
  endfunction

  // A round's mix is ready once every enabled voice has delivered and
  // N+2 cycles have passed since the last delivery (or the round start).
  function automatic void model_tick();
    bit complete;
    int latest, sum;
    m_exp_und = 1'b0;
    if (m_started) begin
      complete = 1'b1;
      latest = m_round_start;
      sum = 0;
      for (int i = 0; i < N; i++) begin
        if (m_mask[i]) begin
          if (!m_rd[i]) complete = 1'b0;
          else begin
            if (m_rcyc[i] > latest) latest = m_rcyc[i];
            sum += m_val[i];
          end
        end
      end
      if (complete && (latest + N + 2 <= cycle)) begin
        m_valid2 = sat_mix(sum, 2);
        m_valid0 = sat_mix(sum, 0);
      end else begin
        m_exp_und = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_started = 1'b1;
    m_round_start = cycle;
    m_last_tick = cycle;
    m_mask = voice_enable;
    for (int i = 0; i < N; i++) m_rd[i] = 1'b0;
  endfunction

  task automatic step();
    bit tick;
    bit exp_gen;
    if (!reset) begin
      model_reset();
    end else begin
      tick = new_frame && !m_nf;
      m_nf = new_frame;
      if (tick) model_tick();
      for (int i = 0; i < N; i++) begin
        if (voice_ready[i]) begin
          m_rd[i] = 1'b1;
          m_val[i] = int'($signed(voice_sample[i*W +: W]));
          m_rcyc[i] = cycle;
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    exp_gen = (cycle == m_last_tick + 1);
    check("gen_s2", 32'(gen2), 32'(exp_gen));
    check("gen_s0", 32'(gen0), 32'(exp_gen));
    check("underrun_s2", 32'(und2), 32'(exp_gen && m_exp_und));
    check("underrun_s0", 32'(und0), 32'(exp_gen && m_exp_und));
    check("valid_s2", 32'($signed(valid2)), m_valid2);
    check("valid_s0", 32'($signed(valid0)), m_valid0);
    check("count_s2", 32'(cnt2), m_cnt);
    check("count_s0", 32'(cnt0), m_cnt);
  endtask

  // offs[i]: cycle within the frame of voice i's real ready (-1 none);
  // reps[i]: earlier ready carrying a throwaway sample (-1 none).
  task automatic run_frame(input logic [N-1:0] mask, input arr_t vals,
                           input arr_t offs, input arr_t reps,
                           input int len, input int hold);
    for (int k = 0; k < len; k++) begin
      new_frame = (k < hold);
      voice_enable = (k == 0) ? mask : N'($urandom);
      voice_sample = {$urandom, $urandom};
      voice_ready = '0;
      for (int i = 0; i < N; i++) begin
        if (offs[i] == k) begin
          voice_ready[i] = 1'b1;
          voice_sample[i*W +: W] = W'(vals[i]);
        end else if (reps[i] == k) begin
          voice_ready[i] = 1'b1;
        end
      end
      step();
    end
  endtask

  localparam arr_t c_none = '{-1, -1, -1, -1};

  initial begin
    model_reset();
    repeat (2) step();
    check("reset_valid", 32'($signed(valid2)), 0);
    check("reset_count", 32'(cnt2), 0);

    // Release with new_frame already high: no tick.
    new_frame = 1'b1;
    reset = 1'b1;
    repeat (3) step();
    new_frame = 1'b0;
    step();

    run_frame(4'b1111, '{1000, 2000, 3000, 4000}, '{1, 2, 3, 4}, c_none, 12, 1);
    check("idle_tick_no_underrun", 32'(cnt2), 0);
    run_frame(4'b1111, '{20000, 20000, 20000, 20000}, '{0, 1, 2, 3}, c_none, 12, 1);
    check("mix_s2", 32'($signed(valid2)), 2500);
    check("mix_s0", 32'($signed(valid0)), 10000);
    run_frame(4'b0101, '{400, 9999, -800, 9999}, '{2, -1, 5, -1}, c_none, 12, 1);
    check("sat_pos_s0", 32'($signed(valid0)), 32767);
    check("sat_pos_s2", 32'($signed(valid2)), 20000);
    run_frame(4'b1111, '{-32768, -32768, -32768, -32768}, '{1, 1, 1, 1}, c_none, 12, 1);
    check("mask_s2", 32'($signed(valid2)), -100);
    check("mask_count", 32'(cnt2), 0);
    run_frame(4'b0000, '{5, 6, 7, 8}, c_none, c_none, 8, 1);
    check("sat_neg_s0", 32'($signed(valid0)), -32768);
    check("sat_neg_s2", 32'($signed(valid2)), -32768);
    run_frame(4'b1111, '{11, 22, 33, 44}, '{1, 2, -1, 3}, c_none, 12, 1);
    check("all_off_s2", 32'($signed(valid2)), 0);
    run_frame(4'b1111, '{100, 200, 300, 400}, '{1, 2, 3, 4}, c_none, 14, 10);
    check("underrun_hold", 32'($signed(valid2)), 0);
    check("underrun_count1", 32'(cnt2), 1);
    run_frame(4'b1111, '{4, 8, 12, 16}, '{1, 1, 2, 2}, c_none, 12, 1);
    check("after_underrun_s2", 32'($signed(valid2)), 250);

    for (int f = 0; f < 40; f++) begin
      arr_t vals, offs, reps;
      logic [N-1:0] mask;
      int g, mx, latest, len, nen;
      mask = N'($urandom);
      nen = 0;
      g = -1;
      for (int i = 0; i < N; i++) begin
        vals[i] = int'($urandom_range(0, 65535)) - 32768;
        offs[i] = -1;
        reps[i] = -1;
        if (mask[i]) begin
          nen++;
          if (g < 0 || $urandom_range(0, 1) == 1) g = i;
        end
      end
      mx = 0;
      for (int i = 0; i < N; i++) begin
        if (mask[i] && i != g) begin
          offs[i] = int'($urandom_range(0, 4));
          if (offs[i] > mx) mx = offs[i];
          if (offs[i] > 0 && $urandom_range(0, 1) == 1)
            reps[i] = int'($urandom_range(0, offs[i] - 1));
        end
      end
      latest = 0;
      if (g >= 0) begin
        offs[g] = (nen > 1) ? mx + 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
        latest = offs[g];
        if ($urandom_range(0, 7) == 0) offs[g] = -1;
      end
      len = latest + N + 2 + int'($urandom_range(0, 4)) - 1;
      for (int i = 0; i < N; i++) begin
        if (!mask[i] && $urandom_range(0, 1) == 1) offs[i] = int'($urandom_range(0, len - 1));
      end
      run_frame(mask, vals, offs, reps, len, int'($urandom_range(1, 3)));
    end

    for (int f = 0; f < 300; f++) begin
      run_frame(4'b1111, '{0, 0, 0, 0}, c_none, c_none, 3, 1);
    end
    check("count_saturated", 32'(cnt2), 255);

    // Abort mid-MIX (index 2): readies at offset 1, mix starts 2 cycles later.
    run_frame(4'b1111, '{1, 2, 3, 4}, '{1, 1, 1, 1}, c_none, 5, 1);
    new_frame = 1'b1;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'($signed(valid2)), 0);
    check("async_rst_count", 32'(cnt2), 0);
    check("async_rst_underrun", 32'(und2), 0);
    check("async_rst_gen", 32'(gen2), 0);
    check("async_rst_count_s0", 32'(cnt0), 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    new_frame = 1'b0;
    step();
    run_frame(4'b1111, '{1000, 2000, 3000, 4000}, '{1, 2, 3, 4}, c_none, 12, 1);
    check("post_rst_valid", 32'($signed(valid2)), 0);
    check("post_rst_count", 32'(cnt2), 0);
    run_frame(4'b0000, '{0, 0, 0, 0}, c_none, c_none, 8, 1);
    check("post_rst_mix", 32'($signed(valid2)), 2500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
